// File: rtl/pcint1_ctrl.sv
// Pin-change interrupt controller for Port C group 1 (PCINT[14:8]): PCICR, PCIFR, PCMSK1 and PCIF1.
// Optional macro PCINT1_SYNC_EN inserts a 2-flop input synchronizer ahead of the edge detector.
module pcint1_ctrl #(
  parameter logic [5:0] PCIFR_Address  = 6'h1B,
  parameter logic [7:0] PCICR_Address  = 8'h68,
  parameter logic [7:0] PCMSK1_Address = 8'h6C
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [5:0] IO_Addr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       out_en,
  input  logic [6:0] pinC_i,
  output logic [6:0] PCINT,
  output logic       PCIE1,
  output logic       pcint1_irq,
  input  logic       pcint1_ack
);

  logic [6:0] pcmsk1_r;
  logic       pcie1_r;
  logic       pcif1_r;
  logic [6:0] prev_r;
  logic       primed_r;
  logic [6:0] pin_s;
  logic [6:0] chg_s;
  logic       pcifr_hit_s;
  logic       pcicr_hit_s;
  logic       pcmsk1_hit_s;

  assign pcifr_hit_s  = (IO_Addr == PCIFR_Address);
  assign pcicr_hit_s  = (ramadr == PCICR_Address);
  assign pcmsk1_hit_s = (ramadr == PCMSK1_Address);

`ifdef PCINT1_SYNC_EN
  logic [6:0] sync1_r;
  logic [6:0] sync2_r;

  // Two-flop synchronizer for pins that are asynchronous to cp2
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      sync1_r <= 7'b0;
      sync2_r <= 7'b0;
    end else begin
      sync1_r <= pinC_i;
      sync2_r <= sync1_r;
    end
  end

  assign pin_s = sync2_r;
`else
  assign pin_s = pinC_i;
`endif

  // Previous-sample register and priming flag for edge detection
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      prev_r   <= 7'b0;
      primed_r <= 1'b0;
    end else begin
      prev_r   <= pin_s;
      primed_r <= 1'b1;
    end
  end

  // Masked change vector; suppressed until prev holds a real sample after reset
  always_comb begin
    chg_s = 7'b0;
    if (primed_r) begin
      chg_s = (pin_s ^ prev_r) & pcmsk1_r;
    end else begin
      chg_s = 7'b0;
    end
  end

  // Configuration registers PCMSK1 and PCICR
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      pcmsk1_r <= 7'b0;
      pcie1_r  <= 1'b0;
    end else begin
      if (ramwe && pcmsk1_hit_s) begin
        pcmsk1_r <= dbus_in[6:0];
      end
      if (ramwe && pcicr_hit_s) begin
        pcie1_r <= dbus_in[1];
      end
    end
  end

  // PCIF1: a new edge beats any clear in the same cycle so no event is lost
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      pcif1_r <= 1'b0;
    end else if (|chg_s) begin
      pcif1_r <= 1'b1;
    end else if (pcint1_ack) begin
      pcif1_r <= 1'b0;
    end else if (iowe && pcifr_hit_s && dbus_in[1]) begin
      pcif1_r <= 1'b0;
    end else begin
      pcif1_r <= pcif1_r;
    end
  end

  // Combinational read-back; quiet while reset is held
  always_comb begin
    dbus_out = 8'h00;
    out_en   = 1'b0;
    if (!ireset) begin
      dbus_out = 8'h00;
      out_en   = 1'b0;
    end else if (iore && pcifr_hit_s) begin
      dbus_out = {6'b0, pcif1_r, 1'b0};
      out_en   = 1'b1;
    end else if (ramre && pcicr_hit_s) begin
      dbus_out = {6'b0, pcie1_r, 1'b0};
      out_en   = 1'b1;
    end else if (ramre && pcmsk1_hit_s) begin
      dbus_out = {1'b0, pcmsk1_r};
      out_en   = 1'b1;
    end else begin
      dbus_out = 8'h00;
      out_en   = 1'b0;
    end
  end

  assign PCINT      = pcmsk1_r;
  assign PCIE1      = pcie1_r;
  assign pcint1_irq = pcif1_r & pcie1_r;

endmodule

// File: tb/tb_pcint1_ctrl.sv
// Directed testbench for pcint1_ctrl; expected values are hand-computed from the register map.
module tb_pcint1_ctrl;

`ifdef PCINT1_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [5:0] IO_Addr;
  logic       iore;
  logic       iowe;
  logic [7:0] ramadr;
  logic       ramre;
  logic       ramwe;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       out_en;
  logic [6:0] pinC_i;
  logic [6:0] PCINT;
  logic       PCIE1;
  logic       pcint1_irq;
  logic       pcint1_ack;

  int vectors = 0;
  int miscompares = 0;

  pcint1_ctrl dut (
    .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
    .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dbus_in(dbus_in),
    .dbus_out(dbus_out), .out_en(out_en), .pinC_i(pinC_i), .PCINT(PCINT),
    .PCIE1(PCIE1), .pcint1_irq(pcint1_irq), .pcint1_ack(pcint1_ack)
  );

  always #5 cp2 = ~cp2;

  task automatic ram_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge cp2);
    ramadr = a; dbus_in = d; ramwe = 1'b1;
    @(negedge cp2);
    ramwe = 1'b0;
  endtask

  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge cp2);
    IO_Addr = a; dbus_in = d; iowe = 1'b1;
    @(negedge cp2);
    iowe = 1'b0;
  endtask

  task automatic ram_rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
    @(negedge cp2);
    ramadr = a; ramre = 1'b1;
    #1;
    d = dbus_out; oe = out_en;
    ramre = 1'b0;
  endtask

  task automatic io_rd(input logic [5:0] a, output logic [7:0] d, output logic oe);
    @(negedge cp2);
    IO_Addr = a; iore = 1'b1;
    #1;
    d = dbus_out; oe = out_en;
    iore = 1'b0;
  endtask

  task automatic set_pins(input logic [6:0] v);
    @(negedge cp2);
    pinC_i = v;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic oe;
    ireset = 1'b0; pinC_i = 7'h7F; IO_Addr = 6'h1B; iore = 1'b1; iowe = 1'b0;
    ramadr = 8'h00; ramre = 1'b0; ramwe = 1'b0; dbus_in = 8'h00; pcint1_ack = 1'b0;
    #3;
    vectors++;
    if ({PCINT, PCIE1, pcint1_irq, out_en, dbus_out} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: PCINT=%h PCIE1=%b irq=%b out_en=%b dbus_out=%h, required all 0",
               PCINT, PCIE1, pcint1_irq, out_en, dbus_out);
    end
    iore = 1'b0;
    repeat (2) @(negedge cp2);
    ireset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge cp2);
      vectors++;
      if (pcint1_irq !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_no_irq[%0d]: irq=%b, required 0", i, pcint1_irq);
      end
    end
    io_rd(6'h1B, d, oe);
    vectors++;
    if (d !== 8'h00 || oe !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_read_pcifr: dbus_out=%h out_en=%b, required 00 / 1", d, oe);
    end
  endtask

  task automatic test_basic_irq;
    logic [7:0] d;
    logic oe;
    set_pins(7'h7B);
    repeat (LAT + 1) @(negedge cp2);
    ram_wr(8'h6C, 8'h04);
    ram_wr(8'h68, 8'h02);
    vectors++;
    if (PCINT !== 7'h04 || PCIE1 !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_config: PCINT=%h PCIE1=%b, required 04 / 1", PCINT, PCIE1);
    end
    set_pins(7'h7F);
    for (int i = 0; i < LAT; i++) begin
      #1;
      vectors++;
      if (pcint1_irq !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_early[%0d]: irq=%b, required 0", i, pcint1_irq);
      end
      @(posedge cp2);
    end
    #1;
    vectors++;
    if (pcint1_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency: irq=%b, required 1 after %0d edges", pcint1_irq, LAT);
    end
    io_rd(6'h1B, d, oe);
    vectors++;
    if (d !== 8'h02 || oe !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_pcifr: dbus_out=%h out_en=%b, required 02 / 1", d, oe);
    end
    @(negedge cp2);
    pcint1_ack = 1'b1;
    @(negedge cp2);
    pcint1_ack = 1'b0;
    vectors++;
    if (pcint1_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ack: irq=%b, required 0", pcint1_irq);
    end
    io_rd(6'h1B, d, oe);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL basic_ack_pcifr: dbus_out=%h, required 00", d);
    end
  endtask

  task automatic test_masked_pin;
    logic [7:0] d;
    logic oe;
    set_pins(7'h5F);
    repeat (LAT + 2) @(negedge cp2);
    vectors++;
    if (pcint1_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL masked_irq: irq=%b, required 0", pcint1_irq);
    end
    io_rd(6'h1B, d, oe);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL masked_pcifr: dbus_out=%h, required 00", d);
    end
    ram_rd(8'h6C, d, oe);
    vectors++;
    if (d !== 8'h04 || oe !== 1'b1) begin
      miscompares++;
      $display("FAIL masked_pcmsk1: dbus_out=%h out_en=%b, required 04 / 1", d, oe);
    end
    set_pins(7'h7F);
    repeat (LAT + 2) @(negedge cp2);
  endtask

  task automatic test_collision;
    logic [7:0] d;
    logic oe;
    set_pins(7'h7B);
    for (int i = 0; i < LAT - 1; i++) @(negedge cp2);
    IO_Addr = 6'h1B; dbus_in = 8'h02; iowe = 1'b1;
    @(negedge cp2);
    iowe = 1'b0;
    vectors++;
    if (pcint1_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_set_wins: irq=%b, required 1", pcint1_irq);
    end
    io_wr(6'h1B, 8'h02);
    vectors++;
    if (pcint1_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_w1c: irq=%b, required 0", pcint1_irq);
    end
    set_pins(7'h7F);
    repeat (LAT + 1) @(negedge cp2);
    io_wr(6'h1B, 8'h00);
    io_rd(6'h1B, d, oe);
    vectors++;
    if (d !== 8'h02 || pcint1_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_w0: dbus_out=%h irq=%b, required 02 / 1", d, pcint1_irq);
    end
    io_wr(6'h1B, 8'hFF);
    vectors++;
    if (pcint1_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_wff: irq=%b, required 0", pcint1_irq);
    end
  endtask

  task automatic test_deferred_enable;
    logic [7:0] d;
    logic oe;
    ram_wr(8'h68, 8'h00);
    ram_wr(8'h6C, 8'h01);
    vectors++;
    if (PCIE1 !== 1'b0 || PCINT !== 7'h01) begin
      miscompares++;
      $display("FAIL deferred_config: PCIE1=%b PCINT=%h, required 0 / 01", PCIE1, PCINT);
    end
    set_pins(7'h7E);
    repeat (LAT + 1) @(negedge cp2);
    io_rd(6'h1B, d, oe);
    vectors++;
    if (d !== 8'h02 || pcint1_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL deferred_flag: dbus_out=%h irq=%b, required 02 / 0", d, pcint1_irq);
    end
    ram_wr(8'h68, 8'h02);
    vectors++;
    if (pcint1_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL deferred_irq: irq=%b, required 1", pcint1_irq);
    end
    ram_rd(8'h68, d, oe);
    vectors++;
    if (d !== 8'h02 || oe !== 1'b1) begin
      miscompares++;
      $display("FAIL deferred_pcicr: dbus_out=%h out_en=%b, required 02 / 1", d, oe);
    end
    ram_wr(8'h68, 8'hFF);
    ram_rd(8'h68, d, oe);
    vectors++;
    if (d !== 8'h02) begin
      miscompares++;
      $display("FAIL deferred_pcicr_ff: dbus_out=%h, required 02", d);
    end
    ram_wr(8'h6C, 8'hFF);
    ram_rd(8'h6C, d, oe);
    vectors++;
    if (d !== 8'h7F) begin
      miscompares++;
      $display("FAIL pcmsk1_bit7: dbus_out=%h, required 7F", d);
    end
    ram_wr(8'h6C, 8'h01);
    @(negedge cp2);
    ramadr = 8'h00;
    #1;
    vectors++;
    if (out_en !== 1'b0 || dbus_out !== 8'h00) begin
      miscompares++;
      $display("FAIL idle_bus: out_en=%b dbus_out=%h, required 0 / 00", out_en, dbus_out);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] d;
    logic oe;
    @(negedge cp2);
    vectors++;
    if (pcint1_irq !== 1'b1 || PCIE1 !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre: irq=%b PCIE1=%b, required 1 / 1", pcint1_irq, PCIE1);
    end
    #1 ireset = 1'b0;
    #1;
    vectors++;
    if (pcint1_irq !== 1'b0 || PCINT !== 7'h00 || PCIE1 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: irq=%b PCINT=%h PCIE1=%b, required 0 / 00 / 0",
               pcint1_irq, PCINT, PCIE1);
    end
    #2 ireset = 1'b1;
    repeat (LAT + 2) @(negedge cp2);
    io_rd(6'h1B, d, oe);
    vectors++;
    if (d !== 8'h00 || pcint1_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL async_release: dbus_out=%h irq=%b, required 00 / 0", d, pcint1_irq);
    end
  endtask

  initial begin
    test_reset();
    test_basic_irq();
    test_masked_pin();
    test_collision();
    test_deferred_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/pcint1_ctrl.md
Name: pcint1_ctrl

Overview:
- Pin-change interrupt controller for Port C (PCINT[14:8], group 1).
- Owns the PCICR, PCIFR and PCMSK1 registers, and drives the PCINT[6:0] and PCIE1 configuration inputs of Port_C.
- Detects masked edges on the Port C input data (DIC_o) and maintains flag PCIF1.
- Raises an interrupt request toward the core's interrupt unit and clears the flag on vector acknowledge.

Parameters:
- PCIFR_Address, 6'h1B, I/O-space address of PCIFR.
- PCICR_Address, 8'h68, extended data-space address of PCICR.
- PCMSK1_Address, 8'h6C, extended data-space address of PCMSK1.

Ports:
- cp2  input  1  system clock; all state updates on rising edge.
- ireset  input  1  asynchronous reset, active-low.
- IO_Addr  input  6  I/O address, used for PCIFR.
- iore  input  1  I/O read strobe.
- iowe  input  1  I/O write strobe.
- ramadr  input  8  data-space address, used for PCICR and PCMSK1.
- ramre  input  1  data-space read strobe.
- ramwe  input  1  data-space write strobe.
- dbus_in  input  8  write data.
- dbus_out  output  8  read data.
- out_en  output  1  read-data valid; high when this block drives dbus_out.
- pinC_i  input  7  Port C pin data (from Port_C DIC_o).
- PCINT  output  7  PCMSK1[6:0], to Port_C.
- PCIE1  output  1  PCICR[1], to Port_C.
- pcint1_irq  output  1  interrupt request, equal to PCIF1 & PCIE1.
- pcint1_ack  input  1  one-cycle vector-taken pulse from the interrupt unit.

Behaviour:
- Reset (ireset=0, asynchronous):
  - PCMSK1, PCICR and PCIFR = 0; edge/sync registers = 0; primed = 0.
  - Outputs during reset: PCINT=0, PCIE1=0, pcint1_irq=0, dbus_out=0, out_en=0.
- Register map:
  - PCICR: only bit1 implemented; other bits read 0 and ignore writes.
  - PCIFR: only bit1 (PCIF1) implemented; other bits read 0.
  - PCMSK1: bits 6:0 implemented; bit7 reads 0.
- Write timing: register writes take effect on the cp2 edge where the strobe is high and the address matches.
  - PCIFR write: writing 1 to bit1 clears PCIF1; writing 0 has no effect.
- Read timing: combinational.
  - out_en=1 and dbus_out=register value in the same cycle as a matching iore/ramre.
  - Otherwise dbus_out=0 and out_en=0.
- Edge detect:
  - s = pinC_i after the input stage (see Optional Feature).
  - prev <= s every cycle.
  - chg = (s ^ prev) & PCMSK1[6:0].
- Priming: primed sets 1 on the first cycle after reset release. While primed=0, chg is forced to 0, so pins high at reset do not produce a false edge.
- PCIF1 update, in priority order:
  1. Set if |chg in this cycle. Set wins over a simultaneous clear (write-1 or ack), so no event is lost.
  2. Else clear on pcint1_ack.
  3. Else clear on PCIFR write with dbus_in[1]=1.
  4. Else hold.
- PCIF1 is set independently of PCIE1. Enabling PCIE1 later with PCIF1=1 raises pcint1_irq immediately, in the cycle after the PCICR write.
- Mask timing: a mask change affects chg from the cycle after the write. A pin toggling in the same cycle as its mask-bit write is not detected.
- Multiple pins changing in one cycle produce a single PCIF1 set. There is no per-pin history and no event counting.
- Latency, pin change to PCIF1=1:
  - With the synchronizer: 3 cp2 edges.
  - Without it: 1 cp2 edge.
- Reset asserted mid-operation clears a pending flag and irq immediately (asynchronous).

Optional Feature:
- Macro: PCINT1_SYNC_EN.
- Defined: pinC_i passes through a 2-flop synchronizer (reset 0) before edge detect. Pin-to-flag latency is 3 cycles. Use when pins are asynchronous to cp2.
- Undefined: s = pinC_i directly, with a single prev register. Latency is 1 cycle; the input must already be synchronous to cp2.

Test Plan:
1. Reset then read: release reset with pinC_i=7'h7F, PCMSK1=0. Read PCIFR → dbus_out=8'h00 and out_en=1 in the read cycle. No irq ever asserts, confirming priming.
2. Basic interrupt:
   - Setup: write PCMSK1=8'h04, PCICR=8'h02.
   - Stimulus: toggle pinC_i[2] 0→1.
   - Response: PCIF1=1 after 3 cycles (SYNC_EN) or 1 cycle (no SYNC_EN), with pcint1_irq=1.
   - Pulse pcint1_ack → PCIF1=0 and irq=0 on the next edge.
3. Masked pin: with PCMSK1=8'h04, toggle pinC_i[5] → PCIF1 stays 0. Reading PCMSK1 returns 8'h04.
4. Set/clear collision: drive a masked edge in the same cycle as a PCIFR write of 8'h02 → PCIF1=1 afterwards. Repeat the write with no edge → PCIF1=0. A write of 8'h00 has no effect.
5. Deferred enable: with PCICR=0, toggle masked pin 0 → PCIF1=1 and irq=0. Write PCICR=8'h02 → irq=1 the next cycle. Read PCICR returns 8'h02; writing 8'hFF reads back 8'h02.
6. Async reset mid-pending: with PCIF1=1 and irq=1, pulse ireset low for half a cycle → irq, PCINT and PCIE1 go to 0 without waiting for a cp2 edge. No flag is set after release.
